// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Load/store controller in front of a 512 x 32-bit synchronous RAM with a
//   one-cycle registered read and no byte enables. It turns byte-addressed
//   byte/halfword/word loads and stores into RAM word accesses. Sub-word
//   stores are done as read-modify-write. Misaligned or out-of-range
//   accesses are rejected without any RAM strobe.
//
// Ports
//   clock, resetn            rising-edge clock, async active-low reset
//   req, we, size,           request (sampled only in IDLE), store flag,
//   signedLoad, addr, wdata  size (00 B, 01 H, 10 W, 11 err), sign-extend
//                            flag, byte address, store data (low bits)
//   rdata, done, err, busy   load result (held), completion pulse, reject
//                            flag (valid with done), not-IDLE
//   memRead, memWrite,       RAM strobes, word index, write data
//   ramAddress, ramDataIn
//   ramDataOut               RAM registered read data
module mem_access_ctrl (
    input  logic        clock,
    input  logic        resetn,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        signedLoad,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic        memRead,
    output logic        memWrite,
    output logic [8:0]  ramAddress,
    output logic [31:0] ramDataIn,
    input  logic [31:0] ramDataOut
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_CAP, S_MERGE, S_WR, S_FAULT
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [10:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        acc_err;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_val;
    logic [31:0] merge_val;

    // Rejection is judged on the live request so IDLE can branch to FAULT
    // at the sampling edge; bits above 10 never need to be latched.
    assign acc_err = (|addr[31:11])
                   || (size == 2'b11)
                   || (size == 2'b01 && addr[0])
                   || (size == 2'b10 && addr[1:0] != 2'b00);

    // Lane extraction and lane replacement on the word the RAM returned.
    always_comb begin
        byte_v = ramDataOut[{addr_q[1:0], 3'b000} +: 8];
        half_v = ramDataOut[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_val = {{24{sgn_q & byte_v[7]}}, byte_v};
            2'b01:   load_val = {{16{sgn_q & half_v[15]}}, half_v};
            default: load_val = ramDataOut;
        endcase
        merge_val = ramDataOut;
        if (size_q == 2'b00)
            merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    size_d  = size;
                    sgn_d   = signedLoad;
                    addr_d  = addr[10:0];
                    wdata_d = wdata;
                    if (acc_err)                   state_d = S_FAULT;
                    else if (!we || size != 2'b10) state_d = S_RD;
                    else                           state_d = S_WR;
                end
            end
            S_RD:    state_d = we_q ? S_MERGE : S_CAP;
            S_CAP: begin
                rdata_d = load_val;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_MERGE: begin
                merge_d = merge_val;
                state_d = S_WR;
            end
            S_WR: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_FAULT: begin
                done_d  = 1'b1;
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // RAM strobes decode straight from state so an async reset drops them
    // immediately.
    assign busy       = (state_q != S_IDLE);
    assign memRead    = (state_q == S_RD);
    assign memWrite   = (state_q == S_WR);
    assign ramAddress = (state_q == S_RD || state_q == S_WR) ? addr_q[10:2] : 9'd0;
    // Word stores skip MERGE, so they write the latched data directly.
    assign ramDataIn  = (state_q != S_WR)  ? 32'd0 :
                        (size_q == 2'b10)  ? wdata_q : merge_q;
    assign rdata      = rdata_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
